ltl_report_arbiter: RTL and testbench



---
 rtl/ltl_mon_pkg.sv | 16 +
 rtl/ltl_report_arbiter_rr_arbiter.sv | 55 +++++
 rtl/ltl_report_arbiter.sv | 133 +++++++++++++
 tb/tb_ltl_report_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared defaults and report record for the LTL monitor cluster slice.
// Used by the report arbiter and its round-robin picker.
package ltl_mon_pkg;

    localparam int DEF_NUM_PROPS = 9;
    localparam int DEF_ID_W      = 4;
    localparam int DEF_STAMP_W   = 32;
    localparam int DEF_DROP_W    = 16;

    typedef struct packed {
        logic [DEF_ID_W-1:0]    id;
        logic [DEF_STAMP_W-1:0] stamp;
        logic                   multi;
    } ltl_report_t;

endpackage

// File: rtl/ltl_report_arbiter_rr_arbiter.sv
// Round-robin picker over pending report slots.
// The search starts one past the last granted index and wraps.
module rr_arbiter
    import ltl_mon_pkg::*;
#(
    parameter int NUM_PROPS = DEF_NUM_PROPS,
    parameter int ID_W      = DEF_ID_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PROPS-1:0] req,
    input  logic                 grant_en,
    output logic [NUM_PROPS-1:0] grant,
    output logic [ID_W-1:0]      index,
    output logic                 any
);

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] pick;
    logic            found;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_PROPS; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_PROPS);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && grant_en) begin
            grant[pick] = 1'b1;
        end
    end

    assign index = pick;
    assign any   = found;

    // Reset value makes index 0 the first candidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ID_W'(NUM_PROPS - 1);
        end else if (grant_en && found) begin
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/ltl_report_arbiter.sv
// Captures per-property LTL violation flags into sticky stamped slots
// and drains them one record at a time onto a valid/ready port.
module ltl_report_arbiter
    import ltl_mon_pkg::*;
#(
    parameter int NUM_PROPS = DEF_NUM_PROPS,
    parameter int ID_W      = DEF_ID_W,
    parameter int STAMP_W   = DEF_STAMP_W,
    parameter int DROP_W    = DEF_DROP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [NUM_PROPS-1:0] hits,
    input  logic [NUM_PROPS-1:0] enable,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [ID_W-1:0]      rpt_id,
    output logic [STAMP_W-1:0]   rpt_stamp,
    output logic                 rpt_multi,
    output logic [NUM_PROPS-1:0] pending,
    output logic [DROP_W-1:0]    drop_count
);

    logic [STAMP_W-1:0]   cnt;
    logic [STAMP_W-1:0]   stamps [NUM_PROPS];
    logic [NUM_PROPS-1:0] pend_q;
    logic [NUM_PROPS-1:0] multi_q;
    logic [NUM_PROPS-1:0] qual;
    logic [NUM_PROPS-1:0] clr;
    logic [NUM_PROPS-1:0] drops;
    logic [ID_W-1:0]      gidx;
    logic                 any;
    logic                 free;
    logic                 load;
    logic [DROP_W-1:0]    drop_q;
    logic [DROP_W:0]      ndrop;
    logic [DROP_W:0]      dsum;
    logic                 valid_q;
    ltl_report_t          rec;

    assign qual = run ? (hits & enable) : '0;
    assign free = !valid_q || rpt_ready;
    assign load = free && any;

    rr_arbiter #(
        .NUM_PROPS (NUM_PROPS),
        .ID_W      (ID_W)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (pend_q),
        .grant_en (free),
        .grant    (clr),
        .index    (gidx),
        .any      (any)
    );

    // A slot being drained this cycle may be re-armed by a fresh hit.
    assign drops = qual & pend_q & ~clr;

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            ndrop = ndrop + (DROP_W+1)'(drops[i]);
        end
    end

    assign dsum = {1'b0, drop_q} + ndrop;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            multi_q <= '0;
            for (int i = 0; i < NUM_PROPS; i++) begin
                stamps[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (qual[i] && (clr[i] || !pend_q[i])) begin
                    pend_q[i]  <= 1'b1;
                    multi_q[i] <= 1'b0;
                    stamps[i]  <= cnt;
                end else if (clr[i]) begin
                    pend_q[i]  <= 1'b0;
                    multi_q[i] <= 1'b0;
                end else if (qual[i]) begin
                    multi_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (dsum[DROP_W]) begin
            drop_q <= '1;
        end else begin
            drop_q <= dsum[DROP_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rec     <= '0;
        end else if (load) begin
            valid_q   <= 1'b1;
            rec.id    <= DEF_ID_W'(gidx);
            rec.stamp <= DEF_STAMP_W'(stamps[gidx]);
            rec.multi <= multi_q[gidx];
        end else if (rpt_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rpt_valid  = valid_q;
    assign rpt_id     = ID_W'(rec.id);
    assign rpt_stamp  = STAMP_W'(rec.stamp);
    assign rpt_multi  = rec.multi;
    assign pending    = pend_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_ltl_report_arbiter.sv
// Bench for ltl_report_arbiter: vector table, corner sequences and
// randomized traffic against a slot/queue level reference model.
module tb_ltl_report_arbiter;

    logic        clk;
    logic        reset;
    logic        run;
    logic [8:0]  hits;
    logic [8:0]  enable;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [3:0]  rpt_id;
    logic [31:0] rpt_stamp;
    logic        rpt_multi;
    logic [8:0]  pending;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    ltl_report_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .hits       (hits),
        .enable     (enable),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_id     (rpt_id),
        .rpt_stamp  (rpt_stamp),
        .rpt_multi  (rpt_multi),
        .pending    (pending),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        run;
        logic        rdy;
        logic [8:0]  hits;
        logic [8:0]  en;
        logic        ev;
        logic [3:0]  eid;
        logic [31:0] est;
        logic        emu;
        logic [8:0]  epend;
        logic [15:0] edrop;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: plain per-slot arrays and an integer pointer.
    logic        m_pend  [9];
    logic        m_multi [9];
    logic [31:0] m_stamp [9];
    logic [31:0] m_cnt   = 0;
    int          m_last  = 8;
    int          m_drop  = 0;
    logic        m_valid = 0;
    int          m_id    = 0;
    logic [31:0] m_st    = 0;
    logic        m_mu    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic ru, input logic rd,
                          input logic [8:0] h, input logic [8:0] e);
        reset     = r;
        run       = ru;
        rpt_ready = rd;
        hits      = h;
        enable    = e;
    endtask

    function automatic logic [8:0] m_pend_vec();
        logic [8:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock of the specification's rules, evaluated on current inputs.
    task automatic model_step();
        int g;
        int nd;
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                m_pend[i]  = 1'b0;
                m_multi[i] = 1'b0;
                m_stamp[i] = '0;
            end
            m_cnt = 0; m_last = 8; m_drop = 0;
            m_valid = 0; m_id = 0; m_st = 0; m_mu = 0;
        end else begin
            g = -1;
            if (!m_valid || rpt_ready) begin
                for (int k = 1; k <= 9; k++) begin
                    if (g < 0 && m_pend[(m_last + k) % 9]) g = (m_last + k) % 9;
                end
            end
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_st = m_stamp[g]; m_mu = m_multi[g];
                m_last = g; m_pend[g] = 0; m_multi[g] = 0;
            end else if (rpt_ready) begin
                m_valid = 0;
            end
            nd = 0;
            for (int i = 0; i < 9; i++) begin
                if (run && hits[i] && enable[i]) begin
                    if (m_pend[i]) begin
                        m_multi[i] = 1'b1;
                        nd++;
                    end else begin
                        m_pend[i] = 1'b1; m_multi[i] = 1'b0; m_stamp[i] = m_cnt;
                    end
                end
            end
            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
            if (run) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(rpt_valid), 32'(m_valid));
        chk("m_id", 32'(rpt_id), 32'(m_id));
        chk("m_stamp", rpt_stamp, m_st);
        chk("m_multi", 32'(rpt_multi), 32'(m_mu));
        chk("m_pending", 32'(pending), 32'(m_pend_vec()));
        chk("m_drop", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic add(input logic r, input logic ru, input logic rd,
                       input logic [8:0] h, input logic [8:0] e,
                       input logic ev, input logic [3:0] eid,
                       input logic [31:0] est, input logic emu,
                       input logic [8:0] ep, input logic [15:0] ed);
        vec_t v;
        v = '{r, ru, rd, h, e, ev, eid, est, emu, ep, ed};
        tbl.push_back(v);
    endtask

    initial begin
        set_in(1, 0, 1, 9'h000, 9'h1FF);

        // Single hit at stamp 5, overrun on slot 3, masking and run gating.
        add(1, 0, 1, 9'h000, 9'h1FF, 0, 0, 0, 0, 9'h000, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 1, 9'h000, 9'h1FF, 0, 0, 0, 0, 9'h000, 0);
        add(0, 1, 1, 9'h004, 9'h1FF, 0, 0, 0, 0, 9'h004, 0);
        add(0, 1, 1, 9'h000, 9'h1FF, 1, 2, 5, 0, 9'h000, 0);
        add(0, 1, 1, 9'h000, 9'h1FF, 0, 2, 5, 0, 9'h000, 0);
        add(0, 1, 0, 9'h001, 9'h1FF, 0, 2, 5, 0, 9'h001, 0);
        add(0, 1, 0, 9'h008, 9'h1FF, 1, 0, 8, 0, 9'h008, 0);
        add(0, 1, 0, 9'h008, 9'h1FF, 1, 0, 8, 0, 9'h008, 1);
        add(0, 1, 0, 9'h008, 9'h1FF, 1, 0, 8, 0, 9'h008, 2);
        add(0, 1, 1, 9'h000, 9'h1FF, 1, 3, 9, 1, 9'h000, 2);
        add(0, 1, 1, 9'h000, 9'h1FF, 0, 3, 9, 1, 9'h000, 2);
        add(0, 1, 1, 9'h080, 9'h07F, 0, 3, 9, 1, 9'h000, 2);
        add(0, 0, 1, 9'h002, 9'h1FF, 0, 3, 9, 1, 9'h000, 2);
        add(0, 1, 1, 9'h010, 9'h1FF, 0, 3, 9, 1, 9'h010, 2);
        add(0, 1, 1, 9'h000, 9'h1FF, 1, 4, 15, 0, 9'h000, 2);
        add(0, 1, 1, 9'h000, 9'h1FF, 0, 4, 15, 0, 9'h000, 2);

        foreach (tbl[n]) begin
            set_in(tbl[n].rst, tbl[n].run, tbl[n].rdy, tbl[n].hits, tbl[n].en);
            tick();
            chk("t_valid", 32'(rpt_valid), 32'(tbl[n].ev));
            chk("t_id", 32'(rpt_id), 32'(tbl[n].eid));
            chk("t_stamp", rpt_stamp, tbl[n].est);
            chk("t_multi", 32'(rpt_multi), 32'(tbl[n].emu));
            chk("t_pending", 32'(pending), 32'(tbl[n].epend));
            chk("t_drop", 32'(drop_count), 32'(tbl[n].edrop));
        end

        // Round robin under backpressure: all nine slots hit at stamp 0.
        set_in(1, 0, 0, 9'h000, 9'h1FF); tick();
        set_in(0, 1, 0, 9'h1FF, 9'h1FF); tick();
        chk("rr_pending", 32'(pending), 32'h1FF);
        set_in(0, 0, 0, 9'h000, 9'h1FF); tick();
        chk("rr_first_valid", 32'(rpt_valid), 1);
        chk("rr_first_id", 32'(rpt_id), 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("rr_stall_valid", 32'(rpt_valid), 1);
            chk("rr_stall_id", 32'(rpt_id), 0);
            chk("rr_stall_stamp", rpt_stamp, 0);
        end
        set_in(0, 0, 1, 9'h000, 9'h1FF);
        for (int k = 1; k < 9; k++) begin
            tick();
            chk("rr_valid", 32'(rpt_valid), 1);
            chk("rr_id", 32'(rpt_id), 32'(k));
            chk("rr_stamp", rpt_stamp, 0);
        end
        tick();
        chk("rr_end_valid", 32'(rpt_valid), 0);
        chk("rr_drop", 32'(drop_count), 0);

        // Slot 4 drained in the same cycle it is hit again.
        set_in(0, 1, 1, 9'h010, 9'h1FF); tick();
        tick();
        chk("rl_id", 32'(rpt_id), 4);
        chk("rl_stamp", rpt_stamp, 1);
        chk("rl_pending", 32'(pending), 32'h010);
        chk("rl_drop", 32'(drop_count), 0);
        set_in(0, 0, 1, 9'h000, 9'h1FF); tick();
        chk("rl2_valid", 32'(rpt_valid), 1);
        chk("rl2_id", 32'(rpt_id), 4);
        chk("rl2_stamp", rpt_stamp, 2);
        chk("rl2_multi", 32'(rpt_multi), 0);
        tick();

        // Reset while a record is held and three slots are pending.
        set_in(0, 1, 0, 9'h0E4, 9'h1FF); tick();
        set_in(0, 0, 0, 9'h000, 9'h1FF); tick();
        chk("rs_pre_id", 32'(rpt_id), 5);
        chk("rs_pre_pending", 32'(pending), 32'h0C4);
        set_in(1, 0, 0, 9'h000, 9'h1FF); tick();
        chk("rs_valid", 32'(rpt_valid), 0);
        chk("rs_pending", 32'(pending), 0);
        chk("rs_drop", 32'(drop_count), 0);
        set_in(0, 1, 1, 9'h041, 9'h1FF); tick();
        set_in(0, 0, 1, 9'h000, 9'h1FF); tick();
        chk("rs_first_id", 32'(rpt_id), 0);
        tick();
        chk("rs_second_id", 32'(rpt_id), 6);
        tick();

        // Randomized traffic with occasional resets and enable changes.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                enable = ($urandom_range(0, 1) == 0) ? 9'h1FF : 9'($urandom);
            end
            reset     = ($urandom_range(0, 299) == 0);
            run       = ($urandom_range(0, 3) != 0);
            hits      = 9'($urandom & $urandom & $urandom);
            rpt_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
